// File: rtl/dest_ip_tbl_axi_ctrl.sv
// AXI4-Lite slave that turns host register accesses into single req/ack table
// reads and writes, plus a counter-clear pulse and a saturating ack-timeout counter.
module dest_ip_tbl_axi_ctrl #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_TBL_ADDR_WIDTH   = 5,
    parameter int C_ACK_TIMEOUT      = 16
) (
    input  logic                            AXI_ACLK,
    input  logic                            AXI_RESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            tbl_wr_req,
    output logic [C_TBL_ADDR_WIDTH-1:0]     tbl_wr_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   tbl_wr_data,
    input  logic                            tbl_wr_ack,
    output logic                            tbl_rd_req,
    output logic [C_TBL_ADDR_WIDTH-1:0]     tbl_rd_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   tbl_rd_data,
    input  logic                            tbl_rd_ack,
    output logic [31:0]                     reset,
    output logic [31:0]                     timeout_count
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int TW = C_TBL_ADDR_WIDTH;
    localparam int CW = $clog2(C_ACK_TIMEOUT + 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [DW-1:0] RD_ERR_DATA = DW'(32'hDEADBEEF);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT, RD_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d, rdata_q, rdata_d;
    logic [1:0]      bresp_q, bresp_d, rresp_q, rresp_d;
    logic            clr_q, clr_d;
    logic [31:0]     tmo_q, tmo_d;
    logic            aw_rdy, ar_rdy;

    logic [7:0] aw_off, ar_off;
    logic       aw_tbl, aw_clr, aw_tmo, ar_tbl, ar_clr, ar_tmo;
    assign aw_off = S_AXI_AWADDR[7:0];
    assign ar_off = S_AXI_ARADDR[7:0];
    assign aw_tbl = ~aw_off[7];
    assign aw_clr = (aw_off == 8'h80);
    assign aw_tmo = (aw_off == 8'h84);
    assign ar_tbl = ~ar_off[7];
    assign ar_clr = (ar_off == 8'h80);
    assign ar_tmo = (ar_off == 8'h84);

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:8],
                           S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:8], S_AXI_WSTRB};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_addr_d = rd_addr_q;
        rdata_d   = rdata_q;
        bresp_d   = bresp_q;
        rresp_d   = rresp_q;
        tmo_d     = tmo_q;
        clr_d     = 1'b0;
        aw_rdy    = 1'b0;
        ar_rdy    = 1'b0;
        case (state_q)
            IDLE: begin
                // A complete write (AW and W together) takes priority over a read.
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    aw_rdy = 1'b1;
                    if (aw_tbl) begin
                        wr_addr_d = S_AXI_AWADDR[TW+1:2];
                        wr_data_d = S_AXI_WDATA;
                        state_d   = WR_REQ;
                    end else begin
                        bresp_d = (aw_clr || aw_tmo) ? RESP_OKAY : RESP_SLVERR;
                        clr_d   = aw_clr & S_AXI_WDATA[0];
                        state_d = WR_RESP;
                    end
                end else if (S_AXI_ARVALID) begin
                    ar_rdy = 1'b1;
                    if (ar_tbl) begin
                        rd_addr_d = S_AXI_ARADDR[TW+1:2];
                        state_d   = RD_REQ;
                    end else begin
                        rresp_d = (ar_clr || ar_tmo) ? RESP_OKAY : RESP_SLVERR;
                        rdata_d = ar_tmo ? DW'(tmo_q) : '0;
                        state_d = RD_RESP;
                    end
                end
            end
            WR_REQ: begin
                cnt_d   = CW'(1);
                state_d = WR_WAIT;
            end
            // Timeout fires as the counter steps onto C_ACK_TIMEOUT, so the
            // response lands C_ACK_TIMEOUT cycles after the request.
            WR_WAIT: begin
                if (tbl_wr_ack) begin
                    bresp_d = RESP_OKAY;
                    state_d = WR_RESP;
                end else if (cnt_q == CW'(C_ACK_TIMEOUT - 1)) begin
                    bresp_d = RESP_SLVERR;
                    tmo_d   = (&tmo_q) ? tmo_q : tmo_q + 32'd1;
                    state_d = WR_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WR_RESP: if (S_AXI_BREADY) state_d = IDLE;
            RD_REQ: begin
                cnt_d   = CW'(1);
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (tbl_rd_ack) begin
                    rresp_d = RESP_OKAY;
                    rdata_d = tbl_rd_data;
                    state_d = RD_RESP;
                end else if (cnt_q == CW'(C_ACK_TIMEOUT - 1)) begin
                    rresp_d = RESP_SLVERR;
                    rdata_d = RD_ERR_DATA;
                    tmo_d   = (&tmo_q) ? tmo_q : tmo_q + 32'd1;
                    state_d = RD_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RD_RESP: if (S_AXI_RREADY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
            rdata_q   <= '0;
            bresp_q   <= '0;
            rresp_q   <= '0;
            clr_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_addr_q <= rd_addr_d;
            rdata_q   <= rdata_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            clr_q     <= clr_d;
            tmo_q     <= tmo_d;
        end
    end

    assign S_AXI_AWREADY = aw_rdy;
    assign S_AXI_WREADY  = aw_rdy;
    assign S_AXI_ARREADY = ar_rdy;
    assign S_AXI_BVALID  = (state_q == WR_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = (state_q == RD_RESP);
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign tbl_wr_req    = (state_q == WR_REQ);
    assign tbl_wr_addr   = wr_addr_q;
    assign tbl_wr_data   = wr_data_q;
    assign tbl_rd_req    = (state_q == RD_REQ);
    assign tbl_rd_addr   = rd_addr_q;
    assign reset         = {31'b0, clr_q};
    assign timeout_count = tmo_q;

endmodule

// File: tb/tb_dest_ip_tbl_axi_ctrl.sv
// Bench for dest_ip_tbl_axi_ctrl: 1-cycle table responder model, response scoreboards.
module tb_dest_ip_tbl_axi_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] S_AXI_AWADDR = '0, S_AXI_WDATA = '0, S_AXI_ARADDR = '0;
    logic [3:0]  S_AXI_WSTRB = 4'hF;
    logic        S_AXI_AWVALID = 1'b0, S_AXI_WVALID = 1'b0, S_AXI_ARVALID = 1'b0;
    logic        S_AXI_BREADY = 1'b1, S_AXI_RREADY = 1'b1;
    logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic [31:0] S_AXI_RDATA;
    logic        tbl_wr_req, tbl_rd_req, tbl_wr_ack, tbl_rd_ack;
    logic [4:0]  tbl_wr_addr, tbl_rd_addr;
    logic [31:0] tbl_wr_data, tbl_rd_data, reset, timeout_count;

    dest_ip_tbl_axi_ctrl dut (
        .AXI_ACLK(clk), .AXI_RESETN(rst_n),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .tbl_wr_req(tbl_wr_req), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
        .tbl_wr_ack(tbl_wr_ack), .tbl_rd_req(tbl_rd_req), .tbl_rd_addr(tbl_rd_addr),
        .tbl_rd_data(tbl_rd_data), .tbl_rd_ack(tbl_rd_ack),
        .reset(reset), .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [1:0] resp; logic [31:0] data; } exp_t;
    exp_t sb_b[$];
    exp_t sb_r[$];
    int n_checks = 0, n_fail = 0;
    int cyc = 0;

    // Responder: acks one cycle after a request; unwritten entries read back a fill pattern.
    logic [31:0] mem [32];
    logic [31:0] mem_valid = '0;
    logic        ack_en = 1'b1, man_rd_ack = 1'b0;
    logic        rsp_wr_ack = 1'b0, rsp_rd_ack = 1'b0;
    logic [31:0] rsp_rd_data = '0;
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        rsp_wr_ack <= tbl_wr_req & ack_en;
        rsp_rd_ack <= tbl_rd_req & ack_en;
        if (tbl_wr_req) begin
            mem[tbl_wr_addr]       <= tbl_wr_data;
            mem_valid[tbl_wr_addr] <= 1'b1;
        end
        rsp_rd_data <= mem_valid[tbl_rd_addr] ? mem[tbl_rd_addr] : {24'hA5A5A5, 3'b000, tbl_rd_addr};
    end
    assign tbl_wr_ack  = rsp_wr_ack;
    assign tbl_rd_ack  = rsp_rd_ack | man_rd_ack;
    assign tbl_rd_data = rsp_rd_data;

    int wr_req_n = 0, rd_req_n = 0, rst_pulse_n = 0;
    int wr_req_cyc = -1, rd_req_cyc = -1, rst_cyc = -1;
    logic [4:0]  wr_req_addr = '0, rd_req_addr = '0;
    logic [31:0] wr_req_data = '0, rst_val = '0;
    always @(negedge clk) begin
        if (tbl_wr_req) begin
            wr_req_n <= wr_req_n + 1; wr_req_cyc <= cyc;
            wr_req_addr <= tbl_wr_addr; wr_req_data <= tbl_wr_data;
        end
        if (tbl_rd_req) begin
            rd_req_n <= rd_req_n + 1; rd_req_cyc <= cyc; rd_req_addr <= tbl_rd_addr;
        end
        if (reset != 32'd0) begin
            rst_pulse_n <= rst_pulse_n + 1; rst_cyc <= cyc; rst_val <= reset;
        end
    end

    task automatic start_write(input logic [31:0] a, input logic [31:0] d, output int hs);
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        hs = -1;
        for (int i = 0; i < 50 && hs < 0; i++) begin
            @(negedge clk);
            if (S_AXI_AWREADY && S_AXI_WREADY) hs = cyc;
            @(posedge clk); #1;
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    endtask

    task automatic start_read(input logic [31:0] a, output int hs);
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
        hs = -1;
        for (int i = 0; i < 50 && hs < 0; i++) begin
            @(negedge clk);
            if (S_AXI_ARREADY) hs = cyc;
            @(posedge clk); #1;
        end
        S_AXI_ARVALID = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp, output int vc);
        vc = -1; resp = 2'bxx;
        for (int i = 0; i < 100 && vc < 0; i++) begin
            @(negedge clk);
            if (S_AXI_BVALID) begin vc = cyc; resp = S_AXI_BRESP; end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_r(output logic [1:0] resp, output logic [31:0] data, output int vc);
        vc = -1; resp = 2'bxx; data = 'x;
        for (int i = 0; i < 100 && vc < 0; i++) begin
            @(negedge clk);
            if (S_AXI_RVALID) begin vc = cyc; resp = S_AXI_RRESP; data = S_AXI_RDATA; end
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [148:0] all_outs();
        return {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_ARREADY,
                S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, tbl_wr_req, tbl_wr_addr, tbl_wr_data,
                tbl_rd_req, tbl_rd_addr, reset, timeout_count};
    endfunction

    task automatic test_reset();
        logic [148:0] o;
        repeat (3) @(posedge clk);
        @(negedge clk); o = all_outs();
        n_checks++;
        if (o !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h, required 0", o); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        int hs, vc, n0; logic [1:0] resp; exp_t e;
        n0 = wr_req_n;
        sb_b.push_back('{2'b00, 32'h0});
        start_write(32'h14, 32'h0A000001, hs);
        wait_b(resp, vc);
        e = sb_b.pop_front();
        n_checks++;
        if (hs < 0 || vc < 0) begin n_fail++; $display("FAIL write_complete: aw=%0d b=%0d, required both seen", hs, vc); end
        n_checks++;
        if (wr_req_n - n0 !== 1) begin n_fail++; $display("FAIL write_req_count: got %0d, required 1", wr_req_n - n0); end
        n_checks++;
        if (wr_req_cyc !== hs + 1) begin n_fail++; $display("FAIL write_req_cycle: got %0d, required %0d", wr_req_cyc, hs + 1); end
        n_checks++;
        if (wr_req_addr !== 5'd5) begin n_fail++; $display("FAIL write_addr: got %0d, required 5", wr_req_addr); end
        n_checks++;
        if (wr_req_data !== 32'h0A000001) begin n_fail++; $display("FAIL write_data: got %h, required 0a000001", wr_req_data); end
        n_checks++;
        if (vc !== hs + 3) begin n_fail++; $display("FAIL write_bvalid_latency: got %0d, required %0d", vc, hs + 3); end
        n_checks++;
        if (resp !== e.resp) begin n_fail++; $display("FAIL write_bresp: got %b, required %b", resp, e.resp); end
    endtask

    task automatic test_read();
        int hs, vc; logic [1:0] resp; logic [31:0] data; exp_t e;
        sb_r.push_back('{2'b00, 32'h0A000001});
        start_read(32'h14, hs);
        wait_r(resp, data, vc);
        e = sb_r.pop_front();
        n_checks++;
        if (rd_req_cyc !== hs + 1) begin n_fail++; $display("FAIL read_req_cycle: got %0d, required %0d", rd_req_cyc, hs + 1); end
        n_checks++;
        if (rd_req_addr !== 5'd5) begin n_fail++; $display("FAIL read_addr: got %0d, required 5", rd_req_addr); end
        n_checks++;
        if (vc !== hs + 3) begin n_fail++; $display("FAIL read_rvalid_latency: got %0d, required %0d", vc, hs + 3); end
        n_checks++;
        if (resp !== e.resp || data !== e.data) begin
            n_fail++; $display("FAIL read_data: got %b/%h, required %b/%h", resp, data, e.resp, e.data);
        end
    endtask

    task automatic test_timeout();
        int hs, vc; logic [1:0] resp; logic [31:0] data; exp_t e;
        ack_en = 1'b0;
        sb_r.push_back('{2'b10, 32'hDEADBEEF});
        start_read(32'h08, hs);
        wait_r(resp, data, vc);
        e = sb_r.pop_front();
        ack_en = 1'b1;
        n_checks++;
        if (rd_req_addr !== 5'd2) begin n_fail++; $display("FAIL timeout_addr: got %0d, required 2", rd_req_addr); end
        n_checks++;
        if (vc < 0 || vc !== rd_req_cyc + 16) begin n_fail++; $display("FAIL timeout_latency: got %0d, required %0d", vc, rd_req_cyc + 16); end
        n_checks++;
        if (resp !== e.resp || data !== e.data) begin
            n_fail++; $display("FAIL timeout_resp: got %b/%h, required %b/%h", resp, data, e.resp, e.data);
        end
        n_checks++;
        if (timeout_count !== 32'd1) begin n_fail++; $display("FAIL timeout_count: got %0d, required 1", timeout_count); end
        sb_r.push_back('{2'b00, 32'd1});
        start_read(32'h84, hs);
        wait_r(resp, data, vc);
        e = sb_r.pop_front();
        n_checks++;
        if (resp !== e.resp || data !== e.data) begin
            n_fail++; $display("FAIL timeout_reg_read: got %b/%h, required %b/%h", resp, data, e.resp, e.data);
        end
    endtask

    task automatic test_decode();
        logic [31:0] waddr [2] = '{32'h90, 32'h84};
        logic [1:0]  wresp [2] = '{2'b10, 2'b00};
        logic [31:0] raddr [4] = '{32'h80, 32'h88, 32'hFC, 32'h84};
        exp_t        rexp  [4] = '{'{2'b00, 32'h0}, '{2'b10, 32'h0}, '{2'b10, 32'h0}, '{2'b00, 32'd1}};
        int hs, vc, n_wr0, n_rd0; logic [1:0] resp; logic [31:0] data; exp_t e;
        n_wr0 = wr_req_n; n_rd0 = rd_req_n;
        for (int i = 0; i < 2; i++) begin
            sb_b.push_back('{wresp[i], 32'h0});
            start_write(waddr[i], 32'h5, hs);
            wait_b(resp, vc);
            e = sb_b.pop_front();
            n_checks++;
            if (resp !== e.resp || vc !== hs + 1) begin
                n_fail++; $display("FAIL decode_write_%h: got %b at +%0d, required %b at +1", waddr[i], resp, vc - hs, e.resp);
            end
        end
        for (int i = 0; i < 4; i++) begin
            sb_r.push_back(rexp[i]);
            start_read(raddr[i], hs);
            wait_r(resp, data, vc);
            e = sb_r.pop_front();
            n_checks++;
            if (resp !== e.resp || data !== e.data || vc !== hs + 1) begin
                n_fail++; $display("FAIL decode_read_%h: got %b/%h at +%0d, required %b/%h at +1", raddr[i], resp, data, vc - hs, e.resp, e.data);
            end
        end
        n_checks++;
        if (wr_req_n !== n_wr0 || rd_req_n !== n_rd0) begin
            n_fail++; $display("FAIL decode_no_table_req: got %0d/%0d reqs, required 0/0", wr_req_n - n_wr0, rd_req_n - n_rd0);
        end
    endtask

    task automatic test_back_to_back();
        int aw_c = -1, ar_c = -1, b_c = -1, r_c = -1;
        logic [1:0] bresp = 2'bxx, rresp = 2'bxx; logic [31:0] rdata = 'x; exp_t eb, er;
        sb_b.push_back('{2'b00, 32'h0});
        sb_r.push_back('{2'b00, 32'h12345678});
        S_AXI_AWADDR = 32'h20; S_AXI_WDATA = 32'h12345678; S_AXI_ARADDR = 32'h20;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 60 && r_c < 0; i++) begin
            @(negedge clk);
            if (S_AXI_AWREADY && aw_c < 0) aw_c = cyc;
            if (S_AXI_ARREADY && ar_c < 0) ar_c = cyc;
            if (S_AXI_BVALID && b_c < 0) begin b_c = cyc; bresp = S_AXI_BRESP; end
            if (S_AXI_RVALID) begin r_c = cyc; rresp = S_AXI_RRESP; rdata = S_AXI_RDATA; end
            @(posedge clk); #1;
            if (aw_c >= 0) begin S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; end
            if (ar_c >= 0) S_AXI_ARVALID = 1'b0;
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        eb = sb_b.pop_front(); er = sb_r.pop_front();
        n_checks++;
        if (aw_c < 0 || b_c !== aw_c + 3) begin n_fail++; $display("FAIL b2b_write_first: aw=%0d b=%0d, required b=aw+3", aw_c, b_c); end
        n_checks++;
        if (ar_c !== b_c + 1) begin n_fail++; $display("FAIL b2b_arready: got %0d, required %0d", ar_c, b_c + 1); end
        n_checks++;
        if (r_c !== ar_c + 3) begin n_fail++; $display("FAIL b2b_rvalid: got %0d, required %0d", r_c, ar_c + 3); end
        n_checks++;
        if (bresp !== eb.resp || rresp !== er.resp || rdata !== er.data) begin
            n_fail++; $display("FAIL b2b_resp: got %b %b/%h, required %b %b/%h", bresp, rresp, rdata, eb.resp, er.resp, er.data);
        end
    endtask

    task automatic test_backpressure_clear();
        int hs, vc = -1, n_wr0, n_rd0, n_wr1, n_rd1, n0; logic [1:0] resp = 2'bxx;
        logic [31:0] data; bit stable = 1'b1, arr = 1'b0; exp_t e;
        n_wr0 = wr_req_n; n_rd0 = rd_req_n;
        S_AXI_BREADY = 1'b0;
        sb_b.push_back('{2'b00, 32'h0});
        start_write(32'h30, 32'hCAFE0030, hs);
        for (int i = 0; i < 20 && vc < 0; i++) begin
            @(negedge clk);
            if (S_AXI_BVALID) begin vc = cyc; resp = S_AXI_BRESP; end
            @(posedge clk); #1;
        end
        S_AXI_ARADDR = 32'h30; S_AXI_ARVALID = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!S_AXI_BVALID || S_AXI_BRESP !== resp) stable = 1'b0;
            if (S_AXI_ARREADY) arr = 1'b1;
            @(posedge clk); #1;
        end
        n_wr1 = wr_req_n; n_rd1 = rd_req_n;
        S_AXI_BREADY = 1'b1;
        e = sb_b.pop_front();
        n_checks++;
        if (vc !== hs + 3 || resp !== e.resp) begin n_fail++; $display("FAIL bp_bresp: got %b at %0d, required %b at %0d", resp, vc, e.resp, hs + 3); end
        n_checks++;
        if (!stable || arr) begin n_fail++; $display("FAIL bp_hold: stable=%0d arready_seen=%0d, required 1/0", stable, arr); end
        n_checks++;
        if (n_wr1 - n_wr0 !== 1 || n_rd1 !== n_rd0) begin
            n_fail++; $display("FAIL bp_no_req: got wr %0d rd %0d, required 1/0", n_wr1 - n_wr0, n_rd1 - n_rd0);
        end
        sb_r.push_back('{2'b00, 32'hCAFE0030});
        start_read(32'h30, hs);
        wait_r(resp, data, vc);
        e = sb_r.pop_front();
        n_checks++;
        if (resp !== e.resp || data !== e.data) begin n_fail++; $display("FAIL bp_read_after: got %b/%h, required %b/%h", resp, data, e.resp, e.data); end
        n0 = rst_pulse_n;
        sb_b.push_back('{2'b00, 32'h0});
        start_write(32'h80, 32'h1, hs);
        wait_b(resp, vc);
        repeat (3) @(posedge clk); #1;
        e = sb_b.pop_front();
        n_checks++;
        if (resp !== e.resp) begin n_fail++; $display("FAIL clear_bresp: got %b, required %b", resp, e.resp); end
        n_checks++;
        if (rst_pulse_n - n0 !== 1 || rst_cyc !== hs + 1 || rst_val !== 32'd1) begin
            n_fail++; $display("FAIL clear_pulse: got %0d cycles at %0d value %h, required 1 at %0d value 1", rst_pulse_n - n0, rst_cyc, rst_val, hs + 1);
        end
        n0 = rst_pulse_n;
        start_write(32'h80, 32'h2, hs);
        wait_b(resp, vc);
        repeat (3) @(posedge clk); #1;
        n_checks++;
        if (rst_pulse_n !== n0) begin n_fail++; $display("FAIL clear_bit0_zero: got %0d pulse cycles, required 0", rst_pulse_n - n0); end
    endtask

    task automatic test_reset_mid_access();
        int hs, vc; bit rv_seen = 1'b0; logic [1:0] resp; logic [31:0] data; logic [148:0] o; exp_t e;
        ack_en = 1'b0;
        start_read(32'h1C, hs);
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b0; #1;
        o = all_outs();
        n_checks++;
        if (o !== '0) begin n_fail++; $display("FAIL reset_mid_outputs: got %h, required 0", o); end
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1; man_rd_ack = 1'b1;
        @(posedge clk); #1; man_rd_ack = 1'b0;
        repeat (20) begin @(negedge clk); if (S_AXI_RVALID) rv_seen = 1'b1; end
        n_checks++;
        if (rv_seen || timeout_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_late_ack: rvalid_seen=%0d timeout_count=%0d, required 0/0", rv_seen, timeout_count);
        end
        @(posedge clk); #1;
        ack_en = 1'b1;
        sb_r.push_back('{2'b00, 32'hA5A5A500});
        start_read(32'h00, hs);
        wait_r(resp, data, vc);
        e = sb_r.pop_front();
        n_checks++;
        if (resp !== e.resp || data !== e.data || vc !== hs + 3) begin
            n_fail++; $display("FAIL reset_then_read: got %b/%h at +%0d, required %b/%h at +3", resp, data, vc - hs, e.resp, e.data);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_decode();
        test_back_to_back();
        test_backpressure_clear();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary, required completion");
        $fatal(1);
    end
endmodule
